// File: rtl/instr_mem_responder.sv
// Instruction-fetch memory responder: one outstanding request, fixed-latency
// response held until handshake, with a preloadable word-addressed RAM.
module instr_mem_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic [31:0] req_addr_i,
  output logic        req_ready_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_data_o,
  output logic        resp_err_o,
  input  logic        resp_ready_i,
  input  logic        load_en_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_data_i,
  output logic [31:0] resp_count_o
);

  localparam int unsigned AW     = $clog2(MEM_WORDS);
  // Span kept at 33 bits so BASE_ADDR + 4*MEM_WORDS cannot wrap.
  localparam logic [32:0] SPAN   = 33'(MEM_WORDS) << 2;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= BASE_ADDR) &&
           ({1'b0, a - BASE_ADDR} < SPAN);
  endfunction

  function automatic logic [AW-1:0] addr_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic [31:0] count_q, count_d;

  logic [31:0] mem_q [MEM_WORDS];
  logic [31:0] rd_word_s;
  logic        req_ok_s;
  logic        accept_s;

  // Write path has no reset; the read below sees pre-write contents.
  always_ff @(posedge clk_i) begin
    if (load_en_i && addr_ok(load_addr_i)) begin
      mem_q[addr_idx(load_addr_i)] <= load_data_i;
    end
  end

  assign rd_word_s = mem_q[addr_idx(req_addr_i)];
  assign req_ok_s  = addr_ok(req_addr_i);
  assign accept_s  = req_valid_i && ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          err_d  = !req_ok_s;
          data_d = req_ok_s ? rd_word_s : NOP_WORD;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            cnt_d   = LAT_M1;
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          count_d = count_q + 32'd1;
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    ready_d = (state_d == IDLE);
    valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign req_ready_o  = ready_q;
  assign resp_valid_o = valid_q;
  assign resp_data_o  = data_q;
  assign resp_err_o   = err_q;
  assign resp_count_o = count_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench: randomized fetches against a memory-map reference model,
// plus a LATENCY=1 instance for back-to-back throughput.
module tb_instr_mem_responder;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          MW    = 1024;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          LAT_A = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, req_ready, resp_valid, resp_err, resp_ready;
  logic [31:0] req_addr, resp_data, resp_count;
  logic        load_en;
  logic [31:0] load_addr, load_data;
  logic        b_req_valid, b_req_ready, b_resp_valid, b_resp_err, b_resp_ready;
  logic [31:0] b_req_addr, b_resp_data, b_resp_count;

  instr_mem_responder #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .LATENCY(LAT_A), .NOP_WORD(NOP)) u_a (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_addr_i(req_addr),
    .req_ready_o(req_ready), .resp_valid_o(resp_valid), .resp_data_o(resp_data),
    .resp_err_o(resp_err), .resp_ready_i(resp_ready), .load_en_i(load_en),
    .load_addr_i(load_addr), .load_data_i(load_data), .resp_count_o(resp_count));

  instr_mem_responder #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .LATENCY(1), .NOP_WORD(NOP)) u_b (
    .clk_i(clk), .rst_i(rst), .req_valid_i(b_req_valid), .req_addr_i(b_req_addr),
    .req_ready_o(b_req_ready), .resp_valid_o(b_resp_valid), .resp_data_o(b_resp_data),
    .resp_err_o(b_resp_err), .resp_ready_i(b_resp_ready), .load_en_i(load_en),
    .load_addr_i(load_addr), .load_data_i(load_data), .resp_count_o(b_resp_count));

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          rr_mode = 1;
  logic [31:0] mdl [MW];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event t=%0t", name, $time);
  endtask

  // Reference memory map with 64-bit arithmetic so the upper bound never wraps.
  function automatic bit in_map(input logic [31:0] a);
    longint unsigned la = 64'(a);
    return (a[1:0] == 2'b00) && (la >= 64'(BASE)) && (la < 64'(BASE) + 64'(4 * MW));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((64'(a) - 64'(BASE)) / 64'd4);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
    if (in_map(a)) mdl[widx(a)] = d;
  endtask

  task automatic issue(input logic [31:0] a, input bit ld, input logic [31:0] la,
                       input logic [31:0] ld_d, input bit post_ld, input logic [31:0] pd);
    int   g = 0;
    exp_t e;
    req_valid = 1'b1;
    req_addr  = a;
    while (!req_ready && g < 100) begin
      step();
      g++;
    end
    if (!req_ready) begin
      timeout("accept_wait");
      req_valid = 1'b0;
      return;
    end
    e.err  = !in_map(a);
    e.data = e.err ? NOP : mdl[widx(a)];
    e.acc  = cyc;
    q.push_back(e);
    if (ld) begin
      load_en = 1'b1; load_addr = la; load_data = ld_d;
    end
    step();
    req_valid = 1'b0;
    load_en   = 1'b0;
    if (ld && in_map(la)) mdl[widx(la)] = ld_d;
    if (post_ld) load_word(a, pd);
  endtask

  task automatic drain();
    int g = 0;
    while ((q.size() != 0 || resp_valid || !req_ready) && g < 200) begin
      step();
      g++;
    end
    if (g >= 200) timeout("drain");
  endtask

  initial begin
    resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      resp_ready = (rr_mode == 0) ? 1'b0 : (rr_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: first cycle of a response pops the scoreboard; stalls must hold.
  initial begin
    logic        prev_v = 1'b0, hs_prev = 1'b0, held_e = 1'b0;
    logic [31:0] held_d = 32'd0;
    int          exp_cnt = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        exp_cnt = 0; prev_v = 1'b0; hs_prev = 1'b0;
      end else begin
        chk("resp_count", resp_count, 32'(exp_cnt));
        if (hs_prev) begin
          chk("idle_after_hs_ready", 32'(req_ready), 32'd1);
          chk("idle_after_hs_valid", 32'(resp_valid), 32'd0);
        end
        if (resp_valid) begin
          chk("ready_low_in_resp", 32'(req_ready), 32'd0);
          if (!prev_v) begin
            if (q.size() == 0) begin
              timeout("unexpected_response");
            end else begin
              e = q.pop_front();
              chk("resp_data", resp_data, e.data);
              chk("resp_err", 32'(resp_err), 32'(e.err));
              chk("latency", 32'(cyc - e.acc), 32'(LAT_A));
              held_d = resp_data; held_e = resp_err;
            end
          end else begin
            chk("stall_data", resp_data, held_d);
            chk("stall_err", 32'(resp_err), 32'(held_e));
          end
        end
        hs_prev = resp_valid && resp_ready;
        prev_v  = resp_valid && !resp_ready;
        if (hs_prev) exp_cnt++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    logic [31:0] a, la, va, vb;
    logic [31:0] eb[$];
    int          g, k, got, last;
    rst = 1'b1; req_valid = 1'b0; req_addr = 32'd0; load_en = 1'b0;
    load_addr = 32'd0; load_data = 32'd0;
    b_req_valid = 1'b0; b_req_addr = 32'd0; b_resp_ready = 1'b1;
    step();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_data", resp_data, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_count", resp_count, 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    load_word(BASE, 32'h0010_0093);
    for (int i = 1; i < 32; i++) load_word(BASE + 32'(4 * i), $urandom);
    load_word(BASE + 32'h0000_0FFC, $urandom);
    load_word(BASE + 32'd1, 32'hDEAD_BEEF);
    load_word(BASE + 32'h0000_1000, 32'hDEAD_BEEF);
    load_word(32'h7FFF_FFFC, 32'hDEAD_BEEF);

    rr_mode = 1;
    issue(BASE, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    drain();
    chk("count_after_first", resp_count, 32'd1);

    rr_mode = 0;
    issue(BASE + 32'd4, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    g = 0;
    while (!resp_valid && g < 20) begin step(); g++; end
    if (!resp_valid) timeout("stall_valid");
    repeat (5) step();
    rr_mode = 1;
    drain();
    chk("count_after_stall", resp_count, 32'd2);

    issue(BASE + 32'd2, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    issue(32'h7FFF_FFFC, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    issue(BASE + 32'h0000_1000, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    issue(BASE + 32'h0000_0FFC, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    drain();

    va = 32'hA5A5_0001; vb = 32'h5A5A_0002;
    load_word(BASE, va);
    issue(BASE, 1'b1, BASE, vb, 1'b0, 32'd0);
    issue(BASE, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    drain();
    chk("model_word0_is_b", mdl[0], vb);

    issue(BASE + 32'd4, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("wait_rst_valid", 32'(resp_valid), 32'd0);
    chk("wait_rst_ready", 32'(req_ready), 32'd0);
    chk("wait_rst_count", resp_count, 32'd0);
    chk("wait_rst_data", resp_data, 32'd0);
    step();
    chk("wait_rst_ready_after", 32'(req_ready), 32'd1);
    issue(BASE + 32'd4, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    drain();

    rr_mode = 2;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = BASE + 32'(4 * (($urandom_range(0, 7) == 0) ? 1023 : $urandom_range(0, 31)));
        6: a = BASE + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(1, 3));
        7: a = {1'b0, 31'($urandom)} & 32'hFFFF_FFFC;
        8: a = (32'h8000_1000 + ($urandom % 32'h7FFF_F000)) & 32'hFFFF_FFFC;
        default: a = ($urandom_range(0, 1) == 0) ? (BASE - 32'd4) : (BASE + 32'h0000_1000);
      endcase
      la = ($urandom_range(0, 1) == 0) ? a : BASE + 32'(4 * $urandom_range(0, 31));
      issue(a, ($urandom_range(0, 3) == 0), la, $urandom, ($urandom_range(0, 3) == 0), $urandom);
    end
    rr_mode = 1;
    drain();

    k = 0; got = 0; last = -1; g = 0;
    while (got < 4 && g < 60) begin
      if (b_resp_valid) begin
        if (eb.size() == 0) begin
          timeout("b_unexpected_response");
        end else begin
          chk("b_data", b_resp_data, eb.pop_front());
        end
        chk("b_err", 32'(b_resp_err), 32'd0);
        if (last >= 0) chk("b_interval", 32'(cyc - last), 32'd2);
        last = cyc;
        got++;
      end
      if (k < 4) begin
        b_req_valid = 1'b1;
        b_req_addr  = BASE + 32'(4 * k);
        if (b_req_ready) begin
          eb.push_back(mdl[k]);
          k++;
        end
      end else begin
        b_req_valid = 1'b0;
      end
      step();
      g++;
    end
    if (got < 4) timeout("b_responses");
    b_req_valid = 1'b0;
    step();
    chk("b_count", b_resp_count, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
- Memory-side responder for the fetch stage's instruction port: accepts one fetch address at a time, returns the addressed 32-bit word after a fixed latency, and holds the response until the consumer takes it.
- Holds an internal word-addressed instruction RAM, preloaded through a separate load port by the testbench or boot logic.
- Sits between the fetch stage and the top-level memory model; it replaces the current zero-latency combinational instruction path.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the RAM (power of two).
- BASE_ADDR, 32'h8000_0000, byte address of word 0; equals the fetch reset PC.
- LATENCY, 2, cycles from request acceptance to resp_valid_o; legal range 1..15.
- NOP_WORD, 32'h0000_0013, data returned on an errored access.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  fetch request present.
- req_addr_i  in  32  byte address of the requested instruction.
- req_ready_o  out  1  responder can accept a request this cycle.
- resp_valid_o  out  1  response data valid.
- resp_data_o  out  32  instruction word.
- resp_err_o  out  1  request was misaligned or out of range.
- resp_ready_i  in  1  consumer takes the response this cycle.
- load_en_i  in  1  RAM write strobe.
- load_addr_i  in  32  byte address for the load write.
- load_data_i  in  32  word to write.
- resp_count_o  out  32  number of completed response handshakes.

Behaviour:
- Reset (rst_i=1 at an edge): state to IDLE; req_ready_o=0 during the reset cycle, then 1; resp_valid_o=0, resp_data_o=0, resp_err_o=0, resp_count_o=0; latency counter cleared.
- Reset drops any in-flight request without a response. RAM contents are not cleared.
- Request accept: occurs when req_valid_i && req_ready_o at an edge. req_ready_o = (state==IDLE).
- State IDLE: on accept, compute the index (req_addr_i-BASE_ADDR)>>2 and latch either the RAM word or NOP_WORD, plus the error flag.
  - If LATENCY==1, go to RESP; otherwise load counter=LATENCY-1 and go to WAIT.
- State WAIT: decrement the counter each cycle; move to RESP when it reaches 1.
  - resp_valid_o rises exactly LATENCY cycles after the accept edge.
- State RESP: resp_valid_o=1; resp_data_o and resp_err_o are stable.
  - On resp_ready_i=1: increment resp_count_o (wraps at 2^32), clear resp_valid_o, return to IDLE. The next accept is possible one cycle later.
  - While resp_ready_i=0, hold all outputs indefinitely. This is the stall case.
- Error conditions:
  - req_addr_i[1:0]!=0: resp_err_o=1, resp_data_o=NOP_WORD.
  - req_addr_i<BASE_ADDR or req_addr_i>=BASE_ADDR+4*MEM_WORDS: resp_err_o=1, resp_data_o=NOP_WORD.
  - Errored requests still follow the full latency and handshake.
- Load port: on load_en_i, write load_data_i to the indexed word every cycle, in any state.
  - Misaligned or out-of-range load addresses are ignored (no write, no flag).
- Simultaneous load and accept to the same word: the read returns the old contents (read-before-write); the write completes.
  - Loads during WAIT or RESP never alter the latched response.
- req_valid_i outside IDLE is ignored. The requester must hold the request until it sees req_ready_o.
- Address arithmetic is 32-bit unsigned. The range check must not wrap when BASE_ADDR+4*MEM_WORDS overflows.

Test Plan:
- Preload 0x8000_0000=32'h0010_0093; with LATENCY=2, request 0x8000_0000 with resp_ready_i=1 -> resp_valid_o high exactly 2 cycles after accept, data 32'h0010_0093, err=0, resp_count_o=1.
- Hold resp_ready_i=0 for 5 cycles after the response -> resp_valid_o and data held stable and req_ready_o=0 throughout; release -> handshake, IDLE next cycle, resp_count_o increments once.
- Request 0x8000_0002, then 0x7FFF_FFFC, then 0x8000_1000 (MEM_WORDS=1024) -> each returns err=1 and data 32'h0000_0013.
- Preload word 0 = A; same cycle, load word 0 = B and accept a request for 0x8000_0000 -> response A; a following request returns B.
- Assert rst_i while in WAIT -> next cycle resp_valid_o=0, req_ready_o=0 then 1, resp_count_o=0; a new request for 0x8000_0004 returns preloaded data (RAM retained).
- Back-to-back sequential fetches of 0x8000_0000..0x8000_000C with LATENCY=1 and resp_ready_i=1 -> four responses in order, one every 2 cycles, resp_count_o=4.
